// File: rtl/ad9958_pkg.sv
// Shared AD9958 definitions: register map, per-register byte length,
// instruction R/W bit and the register-writer state encoding.
package ad9958_pkg;

  localparam logic [4:0] CSR   = 5'h00, FR1   = 5'h01, FR2   = 5'h02, CFR  = 5'h03;
  localparam logic [4:0] CFTW0 = 5'h04, CPOW0 = 5'h05, ACR   = 5'h06, LSRR = 5'h07;
  localparam logic [4:0] RDW   = 5'h08, FDW   = 5'h09;
  localparam logic [4:0] CW1   = 5'h0A, CW2   = 5'h0B, CW3   = 5'h0C, CW4  = 5'h0D;
  localparam logic [4:0] CW5   = 5'h0E, CW6   = 5'h0F, CW7   = 5'h10, CW8  = 5'h11;
  localparam logic [4:0] CW9   = 5'h12, CW10  = 5'h13, CW11  = 5'h14, CW12 = 5'h15;
  localparam logic [4:0] CW13  = 5'h16, CW14  = 5'h17, CW15  = 5'h18;

  localparam logic [4:0] ADDR_MAX = CW15;
  localparam logic       RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT,
    ST_GAP,
    ST_PULSE,
    ST_DONE
  } state_t;

  function automatic logic [2:0] reg_len(input logic [4:0] addr);
    case (addr)
      CSR:              reg_len = 3'd1;
      FR1, CFR, ACR:    reg_len = 3'd3;
      FR2, CPOW0, LSRR: reg_len = 3'd2;
      default:          reg_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/ad9958_nibble_packer.sv
// Packs instruction byte plus MSB-first data bytes into the 4-bit SPI
// sender's nibble stream (nibble 0 at bits [3:0]) and reports the nibble count.
module ad9958_nibble_packer
  import ad9958_pkg::*;
(
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_data,
  output logic [63:0] o_data,
  output logic [4:0]  o_packs
);

  logic [2:0] w_len;
  logic [7:0] w_instr;
  logic [7:0] w_byte;

  always_comb begin
    w_len   = reg_len(i_addr);
    w_instr = {RW_WRITE, 2'b00, i_addr};
    w_byte  = '0;
    o_data  = '0;
    o_data[3:0] = w_instr[7:4];
    o_data[7:4] = w_instr[3:0];
    // Byte b of the stream is data byte (len-b), counted from the LSB end.
    for (int b = 1; b <= 4; b++) begin
      if (b <= int'(w_len)) begin
        w_byte = 8'(i_data >> (8 * (int'(w_len) - b)));
        o_data[8*b +: 4]   = w_byte[7:4];
        o_data[8*b+4 +: 4] = w_byte[3:0];
      end
    end
    o_packs = 5'd2 + {1'b0, w_len, 1'b0};
  end

endmodule

// File: rtl/ad9958_reg_writer.sv
// AD9958 register-write command stage: packs a write, runs the SPI sender
// trigger/busy handshake, and pulses IO_UPDATE when AD9958_REG_WRITER_IOUPD_EN is defined.
module ad9958_reg_writer
  import ad9958_pkg::*;
#(
  parameter int IOUPD_CYCLES = 4,
  parameter int IOUPD_GAP    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_data,
  output logic        req_err,
  output logic        spi_trigger,
  input  logic        spi_busy,
  output logic [4:0]  spi_packs,
  output logic [63:0] spi_data,
  output logic        io_update,
  output logic        done
);

  if (IOUPD_CYCLES < 1 || IOUPD_CYCLES > 255 || IOUPD_GAP < 0 || IOUPD_GAP > 255) begin : g_param_check
    $error("ad9958_reg_writer: IOUPD_CYCLES must be 1..255 and IOUPD_GAP 0..255");
  end

  state_t      r_state, w_next;
  logic        r_armed;
  logic        r_err;
  logic [63:0] r_data;
  logic [4:0]  r_packs;
  logic [63:0] w_pack_data;
  logic [4:0]  w_pack_cnt;
  logic        w_accept;
  logic        w_addr_ok;

  ad9958_nibble_packer u_packer (
    .i_addr  (req_addr),
    .i_data  (req_data),
    .o_data  (w_pack_data),
    .o_packs (w_pack_cnt)
  );

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_addr_ok = (req_addr <= ADDR_MAX);

`ifdef AD9958_REG_WRITER_IOUPD_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clock) begin
    if (!reset_n || (w_next != r_state)) r_cnt <= '0;
    else                                 r_cnt <= r_cnt + 8'd1;
  end
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // r_armed marks that the trigger has been presented to an idle sender, so a
  // busy already high on entry to TRIG is not mistaken for the acknowledge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_armed <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_packs <= '0;
    end else begin
      r_armed <= (r_state == ST_TRIG) && (r_armed || !spi_busy);
      r_err   <= w_accept && !w_addr_ok;
      if (w_accept && w_addr_ok) begin
        r_data  <= w_pack_data;
        r_packs <= w_pack_cnt;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_addr_ok) w_next = ST_TRIG;
      ST_TRIG: if (spi_busy && r_armed) w_next = ST_WAIT;
`ifdef AD9958_REG_WRITER_IOUPD_EN
      ST_WAIT:  if (!spi_busy) w_next = (IOUPD_GAP == 0) ? ST_PULSE : ST_GAP;
      ST_GAP:   if (r_cnt == 8'(IOUPD_GAP - 1)) w_next = ST_PULSE;
      ST_PULSE: if (r_cnt == 8'(IOUPD_CYCLES - 1)) w_next = ST_DONE;
`else
      ST_WAIT:  if (!spi_busy) w_next = ST_DONE;
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    spi_trigger = 1'b0;
    io_update   = 1'b0;
    done        = 1'b0;
    if (reset_n) begin
      case (r_state)
        ST_IDLE:  req_ready   = 1'b1;
        ST_TRIG:  spi_trigger = !spi_busy;
`ifdef AD9958_REG_WRITER_IOUPD_EN
        ST_PULSE: io_update   = 1'b1;
`endif
        ST_DONE:  done        = 1'b1;
        default:  ;
      endcase
    end
  end

  assign req_err   = r_err;
  assign spi_data  = r_data;
  assign spi_packs = r_packs;

endmodule
